// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with any depth, programmable almost-full/almost-empty
// thresholds, optional first-word-fall-through read and a clearable high-water mark.
module sync_fifo_param #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    parameter int FWFT       = 0,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  clr_peak,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CNT_W-1:0]      count,
    output logic [CNT_W-1:0]      peak
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_param: FIFO_DEPTH must be at least 2");
    end
    if (FIFO_WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_param: FIFO_WIDTH must be at least 1");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH) begin : g_bad_af
        $error("sync_fifo_param: AF_LEVEL must lie in 1..FIFO_DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL >= FIFO_DEPTH) begin : g_bad_ae
        $error("sync_fifo_param: AE_LEVEL must lie in 0..FIFO_DEPTH-1");
    end

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count_nxt, peak_nxt;
    logic                  wa, ra;

    // Accept decisions use the occupancy before this edge, so a full FIFO can
    // still pop and an empty FIFO can still push in the same cycle.
    assign wa        = wr_en && (count < CNT_W'(FIFO_DEPTH));
    assign ra        = rd_en && (count != '0);
    assign count_nxt = count + CNT_W'(wa) - CNT_W'(ra);

    always_comb begin
        peak_nxt = peak;
        if (clr_peak || count_nxt > peak) peak_nxt = count_nxt;
    end

    assign full        = (count == CNT_W'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign almostfull  = (count >= CNT_W'(AF_LEVEL)) && !full;
    assign almostempty = (count <= CNT_W'(AE_LEVEL)) && !empty;

    // Explicit wrap at FIFO_DEPTH-1 so non-power-of-two depths address correctly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            peak      <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wa) wr_ptr <= ptr_inc(wr_ptr);
            if (ra) rd_ptr <= ptr_inc(rd_ptr);
            count     <= count_nxt;
            peak      <= peak_nxt;
            wr_ack    <= wa;
            overflow  <= wr_en && !wa;
            underflow <= rd_en && !ra;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst_n && wa) mem[wr_ptr] <= data_in;
    end

    if (FWFT != 0) begin : g_fwft
        assign data_out = mem[rd_ptr];
        assign rd_valid = !empty;
    end else begin : g_reg_rd
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                data_out <= '0;
                rd_valid <= 1'b0;
            end else begin
                rd_valid <= ra;
                if (ra) data_out <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: a depth-5 registered-read FIFO and a depth-8 FWFT FIFO with custom thresholds.
module tb_sync_fifo_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- instance A: depth 5, registered read ----------------
    logic       a_rst_n = 1'b0, a_wr = 1'b0, a_rd = 1'b0, a_clr = 1'b0;
    logic [7:0] a_din = '0, a_dout;
    logic       a_rv, a_ack, a_ovf, a_udf, a_full, a_empty, a_af, a_ae;
    logic [2:0] a_cnt, a_peak;

    sync_fifo_param #(.FIFO_WIDTH(8), .FIFO_DEPTH(5), .FWFT(0)) u_a (
        .clk(clk), .rst_n(a_rst_n), .data_in(a_din), .wr_en(a_wr), .rd_en(a_rd),
        .clr_peak(a_clr), .data_out(a_dout), .rd_valid(a_rv), .wr_ack(a_ack),
        .overflow(a_ovf), .underflow(a_udf), .full(a_full), .empty(a_empty),
        .almostfull(a_af), .almostempty(a_ae), .count(a_cnt), .peak(a_peak)
    );

    // ---------------- instance B: depth 8, FWFT, AF=6, AE=2 ----------------
    logic       b_rst_n = 1'b0, b_wr = 1'b0, b_rd = 1'b0, b_clr = 1'b0;
    logic [7:0] b_din = '0, b_dout;
    logic       b_rv, b_ack, b_ovf, b_udf, b_full, b_empty, b_af, b_ae;
    logic [3:0] b_cnt, b_peak;

    sync_fifo_param #(.FIFO_WIDTH(8), .FIFO_DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_b (
        .clk(clk), .rst_n(b_rst_n), .data_in(b_din), .wr_en(b_wr), .rd_en(b_rd),
        .clr_peak(b_clr), .data_out(b_dout), .rd_valid(b_rv), .wr_ack(b_ack),
        .overflow(b_ovf), .underflow(b_udf), .full(b_full), .empty(b_empty),
        .almostfull(b_af), .almostempty(b_ae), .count(b_cnt), .peak(b_peak)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_op(input logic we, input logic re, input logic [7:0] d);
        a_wr = we; a_rd = re; a_din = d;
        tick();
        a_wr = 1'b0; a_rd = 1'b0;
    endtask

    task automatic b_op(input logic we, input logic re, input logic [7:0] d, input logic clr);
        b_wr = we; b_rd = re; b_din = d; b_clr = clr;
        tick();
        b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0;
    endtask

    logic [7:0] a_exp [5];

    initial begin
        // reset both instances for two cycles
        tick(); tick();
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        chk("a_rst_count", 32'(a_cnt), 0);
        chk("a_rst_empty", 32'(a_empty), 1);
        chk("a_rst_flags", 32'({a_full, a_af, a_ae}), 0);
        chk("a_rst_hs", 32'({a_ack, a_ovf, a_udf, a_rv}), 0);
        chk("a_rst_dout", 32'(a_dout), 0);
        chk("a_rst_peak", 32'(a_peak), 0);

        // fill depth-5 FIFO
        for (int i = 1; i <= 4; i++) a_op(1'b1, 1'b0, 8'(i * 'h11));
        chk("a_cnt4", 32'(a_cnt), 4);
        chk("a_af4", 32'({a_af, a_full}), 'b10);
        chk("a_ack", 32'(a_ack), 1);
        a_op(1'b1, 1'b0, 8'h55);
        chk("a_cnt5", 32'(a_cnt), 5);
        chk("a_af5", 32'({a_af, a_full}), 'b01);
        chk("a_peak5", 32'(a_peak), 5);

        // full boundary
        a_op(1'b1, 1'b0, 8'h99);
        chk("a_ovf", 32'({a_ovf, a_ack}), 'b10);
        chk("a_ovf_cnt", 32'(a_cnt), 5);
        a_op(1'b1, 1'b1, 8'h99);
        chk("a_full_rw_cnt", 32'(a_cnt), 4);
        chk("a_full_rw_ovf", 32'({a_ovf, a_rv}), 'b11);
        chk("a_full_rw_dout", 32'(a_dout), 'h11);

        // two more reads, then refill across the pointer wrap
        a_op(1'b0, 1'b1, 8'h00);
        chk("a_rd22", 32'(a_dout), 'h22);
        a_op(1'b0, 1'b1, 8'h00);
        chk("a_rd33", 32'(a_dout), 'h33);
        a_op(1'b1, 1'b0, 8'h66);
        a_op(1'b1, 1'b0, 8'h77);
        a_op(1'b1, 1'b0, 8'h88);
        chk("a_refill_cnt", 32'(a_cnt), 5);
        a_exp = '{8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 5; i++) begin
            a_op(1'b0, 1'b1, 8'h00);
            chk($sformatf("a_drain%0d", i), 32'({a_rv, a_dout}), 32'({1'b1, a_exp[i]}));
        end
        chk("a_empty", 32'({a_empty, a_cnt}), 'b1000);

        // empty boundary
        a_op(1'b0, 1'b1, 8'h00);
        chk("a_udf", 32'({a_udf, a_rv}), 'b10);
        chk("a_udf_cnt", 32'(a_cnt), 0);
        a_op(1'b1, 1'b1, 8'hAB);
        chk("a_empty_rw_hs", 32'({a_ack, a_udf, a_rv}), 'b110);
        chk("a_empty_rw_cnt", 32'(a_cnt), 1);
        chk("a_empty_rw_ae", 32'(a_ae), 1);
        a_op(1'b0, 1'b1, 8'h00);
        chk("a_rdAB", 32'(a_dout), 'hAB);

        // ---------------- FWFT instance ----------------
        chk("b_rst", 32'({b_rv, b_empty, b_cnt}), 'b010000);
        b_op(1'b1, 1'b0, 8'h3C, 1'b0);
        chk("b_fwft_dout", 32'(b_dout), 'h3C);
        chk("b_fwft_rv", 32'(b_rv), 1);
        chk("b_ae1", 32'(b_ae), 1);
        for (int i = 1; i <= 4; i++) b_op(1'b1, 1'b0, 8'(i), 1'b0);
        chk("b_cnt5_af", 32'({b_af, b_cnt}), 'b00101);
        b_op(1'b1, 1'b0, 8'h05, 1'b0);
        chk("b_cnt6_af", 32'({b_af, b_cnt}), 'b10110);
        b_op(1'b1, 1'b0, 8'h06, 1'b0);
        chk("b_cnt7_af", 32'({b_af, b_full, b_cnt}), 'b100111);
        for (int i = 1; i <= 4; i++) begin
            b_op(1'b0, 1'b1, 8'h00, 1'b0);
            chk($sformatf("b_pop%0d", i), 32'(b_dout), 32'(i));
        end
        chk("b_cnt3_ae", 32'({b_ae, b_cnt}), 'b00011);
        b_op(1'b0, 1'b1, 8'h00, 1'b0);
        chk("b_cnt2_ae", 32'({b_ae, b_cnt}), 'b10010);
        chk("b_head05", 32'(b_dout), 'h05);
        chk("b_peak7", 32'(b_peak), 7);
        b_op(1'b0, 1'b0, 8'h00, 1'b1);
        chk("b_clr_peak", 32'(b_peak), 2);
        b_op(1'b1, 1'b0, 8'h07, 1'b0);
        chk("b_peak3", 32'({b_peak, b_cnt}), 'h33);

        // mid-operation reset with a write request that must be ignored
        b_rst_n = 1'b0;
        b_op(1'b1, 1'b0, 8'hEE, 1'b0);
        b_rst_n = 1'b1;
        chk("b_mid_rst", 32'({b_empty, b_rv, b_cnt}), 'b100000);
        chk("b_mid_rst_peak", 32'(b_peak), 0);
        b_op(1'b0, 1'b1, 8'h00, 1'b0);
        chk("b_udf", 32'(b_udf), 1);
        chk("b_udf_cnt", 32'(b_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
